// File: rtl/dmp_deserial_if.sv
// dmp_deserial_if: stream beat and result handshake bundle for the DMP receive end.
// master drives beats and acks; slave is the deserializer.
interface dmp_deserial_if #(
   parameter int NODES_IN_GRAPH = 32
);
   logic stream_valid;
   logic stream_ready;
   logic stream_start;
   logic stream_last;
   logic [NODES_IN_GRAPH-1:0][63:0] stream_data;
   logic [NODES_IN_GRAPH-1:0][63:0] pagerank_sum;
   logic sum_valid;
   logic sum_ack;
   modport master (
      output stream_valid, stream_start, stream_last, stream_data, sum_ack,
      input  stream_ready, pagerank_sum, sum_valid
   );
   modport slave (
      input  stream_valid, stream_start, stream_last, stream_data, sum_ack,
      output stream_ready, pagerank_sum, sum_valid
   );
endinterface

// File: rtl/dmp_deserial.sv
// dmp_deserial: reduces one frame of per-thread lane vectors in thread order into per-node sums.
// Define DMP_DESERIAL_SAT_EN to saturate lane adds instead of wrapping modulo 2^64.
module dmp_deserial #(
   parameter int NUM_HW_THREADS = 8,
   parameter int NODES_IN_GRAPH = 32,
   localparam int CW = $clog2(NUM_HW_THREADS + 1)
) (
   input  logic          clock,
   input  logic          reset_n,
   dmp_deserial_if.slave s,
   output logic [CW-1:0] beat_count,
   output logic          protocol_error
);
   typedef enum logic [1:0] {IDLE, ACCUM, DONE, ERROR} state_t;
   localparam bit ONE = NUM_HW_THREADS == 1;
   state_t state;
   logic [NODES_IN_GRAPH-1:0][63:0] acc, acc_add;
   logic [CW-1:0] cnt_next;
   logic take, full;

   function automatic logic [63:0] lane_add(input logic [63:0] a, input logic [63:0] b);
`ifdef DMP_DESERIAL_SAT_EN
      logic [64:0] t;
      t = {1'b0, a} + {1'b0, b};
      return t[64] ? '1 : t[63:0];
`else
      return a + b;
`endif
   endfunction

   always_comb begin
      acc_add = '0;
      for (int i = 0; i < NODES_IN_GRAPH; i++) acc_add[i] = lane_add(acc[i], s.stream_data[i]);
   end

   assign take = s.stream_valid && s.stream_ready;
   assign cnt_next = beat_count + CW'(1);
   assign full = cnt_next == CW'(NUM_HW_THREADS);
   assign s.pagerank_sum = acc;

   always_ff @(posedge clock or negedge reset_n)
      if (!reset_n) begin
         state <= IDLE;
         acc <= '0;
         beat_count <= '0;
         protocol_error <= 1'b0;
         s.stream_ready <= 1'b1;
         s.sum_valid <= 1'b0;
      end else if (state == DONE) begin
         if (s.sum_ack) begin
            state <= IDLE;
            beat_count <= '0;
            s.stream_ready <= 1'b1;
            s.sum_valid <= 1'b0;
         end
      end else if (take) begin
         if (state == ACCUM) begin
            acc <= acc_add;
            beat_count <= cnt_next;
            // a last marker is only legal on exactly the final thread's beat
            if (s.stream_start || (s.stream_last != full)) begin
               state <= ERROR;
               protocol_error <= 1'b1;
            end else if (s.stream_last) begin
               state <= DONE;
               s.stream_ready <= 1'b0;
               s.sum_valid <= 1'b1;
            end
         end else if (s.stream_start) begin
            acc <= s.stream_data;
            beat_count <= CW'(1);
            protocol_error <= ONE && !s.stream_last;
            state <= !ONE ? ACCUM : s.stream_last ? DONE : ERROR;
            s.stream_ready <= !(ONE && s.stream_last);
            s.sum_valid <= ONE && s.stream_last;
         end
      end
endmodule
